// File: rtl/proc_trace_pkg.sv
// Shared types for the processor trace sink: the buffered record layout and
// the occupancy classification derived from the FIFO count.
package proc_trace_pkg;

  localparam int unsigned RecWidth = 96;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cycle;
  } trace_rec_t;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  function automatic occ_e occ_state(input int unsigned count, input int unsigned depth);
    if (count == 0) return OccEmpty;
    if (count >= depth) return OccFull;
    return OccPartial;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO of trace records with flush; a push into a full
// FIFO is only accepted when a pop happens in the same cycle.
module trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int unsigned p_depth = 16,
  localparam int unsigned CntW = $clog2(p_depth + 1),
  localparam int unsigned PtrW = $clog2(p_depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  trace_rec_t      i_rec,
  output trace_rec_t      o_head,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  trace_rec_t            r_mem [p_depth];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_count;
  occ_e                  w_occ;
  logic                  w_do_push;
  logic                  w_do_pop;

  always_comb begin
    w_occ     = occ_state(int'(r_count), p_depth);
    o_full    = (w_occ == OccFull);
    o_empty   = (w_occ == OccEmpty);
    w_do_pop  = i_pop & ~o_empty & ~i_clear;
    w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;
    o_head    = r_mem[r_rptr];
    o_count   = r_count;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_rec;
  end

endmodule

// File: rtl/proc_trace_sink.sv
// Non-stalling consumer of the processor trace bus: stamps each record with a
// free-running cycle count, buffers it, and counts records lost to a full FIFO.
module proc_trace_sink
  import proc_trace_pkg::*;
#(
  parameter int unsigned p_depth = 16,
  parameter int unsigned p_dropw = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trace_val,
  input  logic [31:0]                  trace_addr,
  input  logic [31:0]                  trace_data,
  input  logic                         enable,
  input  logic                         clear,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [31:0]                  out_addr,
  output logic [31:0]                  out_data,
  output logic [31:0]                  out_cycle,
  output logic [$clog2(p_depth+1)-1:0] count,
  output logic                         overflow,
  output logic [p_dropw-1:0]           drop_count
);

  logic [31:0]        r_cycle;
  logic               r_overflow;
  logic [p_dropw-1:0] r_drop_count;
  trace_rec_t         w_rec;
  trace_rec_t         w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;

  always_comb begin
    w_rec  = '{addr: trace_addr, data: trace_data, cycle: r_cycle};
    w_push = trace_val & enable & ~clear;
    w_pop  = ~w_empty & out_rdy & ~clear;
    w_drop = w_push & w_full & ~w_pop;
  end

  trace_fifo #(
    .p_depth (p_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (clear),
    .i_rec   (w_rec),
    .o_head  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The cycle stamp keeps running through clear so timestamps stay monotonic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (clear) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != {p_dropw{1'b1}}) r_drop_count <= r_drop_count + p_dropw'(1);
      end
    end
  end

  always_comb begin
    out_val    = ~w_empty;
    out_addr   = out_val ? w_head.addr  : 32'd0;
    out_data   = out_val ? w_head.data  : 32'd0;
    out_cycle  = out_val ? w_head.cycle : 32'd0;
    overflow   = r_overflow;
    drop_count = r_drop_count;
  end

endmodule
